ram16x4_bist: RTL and testbench

//  Synchronous built-in self-test initiator for the asynchronous ram16x4 array.

---
 rtl/ram16x4_bist_pkg.sv | 36 +++
 rtl/ram_access_seq.sv | 66 ++++++
 rtl/ram16x4_bist.sv | 119 +++++++++++
 tb/tb_ram16x4_bist.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ram16x4_bist_pkg.sv
// Shared encodings for the ram16x4 BIST: access-timer states, test phases
// and the expected-data function used for both writing and checking.
package ram16x4_bist_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        PH_W0 = 2'd0,
        PH_R0 = 2'd1,
        PH_W1 = 2'd2,
        PH_R1 = 2'd3
    } phase_t;

    localparam int EXP_W = 16;
    localparam int ERR_W = 6;

    function automatic logic is_write_phase(input phase_t ph);
        return (ph == PH_W0) || (ph == PH_W1);
    endfunction

    // Computed wide; callers truncate to their data width.
    function automatic logic [EXP_W-1:0] exp_data(
        input phase_t           ph,
        input logic [EXP_W-1:0] adrs,
        input logic [EXP_W-1:0] pattern,
        input logic             addr_xor
    );
        logic [EXP_W-1:0] base;
        base = ((ph == PH_W1) || (ph == PH_R1)) ? ~pattern : pattern;
        return addr_xor ? (base ^ adrs) : base;
    endfunction

endpackage

// File: rtl/ram_access_seq.sv
// Per-access SETUP/STROBE/HOLD timer for the asynchronous RAM. Strobes are
// registered from the next state so the RAM pins never glitch.
module ram_access_seq
    import ram16x4_bist_pkg::*;
#(
    parameter int STROBE_CYC = 2
) (
    input  logic clk,
    input  logic _rst,
    input  logic go,
    input  logic is_write,
    output logic ce_n,
    output logic we_n,
    output logic oe_n,
    output logic wdrive,
    output logic sample,
    output logic last
);

    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYC - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] cnt;
    logic          op_write;
    logic          next_write;
    logic          launch;

    assign launch     = go && ((state == ST_IDLE) || (state == ST_HOLD));
    assign next_write = launch ? is_write : op_write;
    assign sample     = (state == ST_STROBE) && (cnt == CNT_LAST) && !op_write;
    assign last       = (state == ST_HOLD);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (go) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_STROBE;
            ST_STROBE: if (cnt == CNT_LAST) next_state = ST_HOLD;
            ST_HOLD:   next_state = go ? ST_SETUP : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            ce_n     <= 1'b1;
            we_n     <= 1'b1;
            oe_n     <= 1'b1;
            wdrive   <= 1'b0;
        end else begin
            state    <= next_state;
            op_write <= next_write;
            cnt      <= (state == ST_STROBE) ? cnt + CW'(1) : '0;
            ce_n     <= (next_state == ST_IDLE);
            we_n     <= !((next_state == ST_STROBE) && next_write);
            oe_n     <= !((next_state == ST_STROBE) && !next_write);
            wdrive   <= (next_state != ST_IDLE) && next_write;
        end
    end

endmodule

// File: rtl/ram16x4_bist.sv
// BIST initiator for ram16x4: march W0/R0/W1/R1 over all cells, counting
// read mismatches and latching the first failing address and data.
module ram16x4_bist
    import ram16x4_bist_pkg::*;
#(
    parameter int             AW         = 4,
    parameter int             DW         = 4,
    parameter logic [DW-1:0]  PATTERN    = '0,
    parameter bit             ADDR_XOR   = 1'b1,
    parameter int             STROBE_CYC = 2
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_fail_adrs,
    output logic [DW-1:0]    first_fail_data,
    output logic [AW-1:0]    adrs,
    output logic [DW-1:0]    ram_wdata,
    output logic             ram_wdrive,
    output logic             _ce,
    output logic             _we,
    output logic             _oe,
    input  logic [DW-1:0]    ram_dout
);

    phase_t        phase;
    phase_t        nxt_phase;
    phase_t        go_phase;
    logic [AW-1:0] nxt_adrs;
    logic [AW-1:0] go_adrs;
    logic [DW-1:0] cur_exp;
    logic [DW-1:0] go_exp;
    logic          start_ok;
    logic          final_access;
    logic          go;
    logic          go_write;
    logic          acc_sample;
    logic          acc_last;
    logic          mismatch;

    assign start_ok     = start && !busy;
    assign final_access = (phase == PH_R1) && (adrs == '1);
    assign nxt_adrs     = adrs + AW'(1);
    assign nxt_phase    = (adrs == '1) ? phase_t'(phase + 2'd1) : phase;

    // The next access is described one cycle early so the timer can
    // register its strobes for the cycle right after the HOLD edge.
    assign go_phase = start_ok ? PH_W0 : nxt_phase;
    assign go_adrs  = start_ok ? '0 : nxt_adrs;
    assign go_write = is_write_phase(go_phase);
    assign go       = start_ok || (busy && acc_last && !final_access);

    assign cur_exp  = DW'(exp_data(phase, EXP_W'(adrs), EXP_W'(PATTERN), ADDR_XOR));
    assign go_exp   = DW'(exp_data(go_phase, EXP_W'(go_adrs), EXP_W'(PATTERN), ADDR_XOR));
    assign mismatch = busy && acc_sample && (ram_dout != cur_exp);

    ram_access_seq #(
        .STROBE_CYC(STROBE_CYC)
    ) u_seq (
        .clk     (clk),
        ._rst    (_rst),
        .go      (go),
        .is_write(go_write),
        .ce_n    (_ce),
        .we_n    (_we),
        .oe_n    (_oe),
        .wdrive  (ram_wdrive),
        .sample  (acc_sample),
        .last    (acc_last)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_adrs <= '0;
            first_fail_data <= '0;
            adrs            <= '0;
            ram_wdata       <= '0;
            phase           <= PH_W0;
        end else if (start_ok) begin
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_adrs <= '0;
            first_fail_data <= '0;
            adrs            <= go_adrs;
            phase           <= go_phase;
            ram_wdata       <= go_exp;
        end else if (busy) begin
            if (mismatch) begin
                err_count <= err_count + ERR_W'(1);
                if (err_count == '0) begin
                    first_fail_adrs <= adrs;
                    first_fail_data <= ram_dout;
                end
            end
            if (acc_last) begin
                if (final_access) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end else begin
                    adrs  <= nxt_adrs;
                    phase <= nxt_phase;
                    if (go_write) ram_wdata <= go_exp;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram16x4_bist.sv
// Directed bench for ram16x4_bist with a behavioural async RAM per instance
// (one default timing, one with single-cycle strobes).
module tb_ram16x4_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       stuck;

    logic       busy0, done0, pass0, wd0, ce0, we0, oe0;
    logic [5:0] err0;
    logic [3:0] ffa0, ffd0, adrs0, wdata0, dout0, bus0;
    logic       busy1, done1, pass1, wd1, ce1, we1, oe1;
    logic [5:0] err1;
    logic [3:0] ffa1, ffd1, adrs1, wdata1, dout1, bus1;

    logic [3:0]  mem0 [16];
    logic [3:0]  mem1 [16];
    logic [11:0] trace [0:399];
    int compared   = 0;
    int mismatched = 0;
    int overlap    = 0;
    int n_done;

    always #5 clk = ~clk;

    ram16x4_bist dut0 (
        .clk(clk), ._rst(rst_n), .start(start0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_adrs(ffa0), .first_fail_data(ffd0),
        .adrs(adrs0), .ram_wdata(wdata0), .ram_wdrive(wd0),
        ._ce(ce0), ._we(we0), ._oe(oe0), .ram_dout(dout0)
    );

    ram16x4_bist #(.STROBE_CYC(1)) dut1 (
        .clk(clk), ._rst(rst_n), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_adrs(ffa1), .first_fail_data(ffd1),
        .adrs(adrs1), .ram_wdata(wdata1), .ram_wdrive(wd1),
        ._ce(ce1), ._we(we1), ._oe(oe1), .ram_dout(dout1)
    );

    // Async RAM models: latch on the rising edge of _we, read while _oe low.
    assign bus0  = wd0 ? wdata0 : 4'h0;
    assign bus1  = wd1 ? wdata1 : 4'h0;
    assign dout0 = (!ce0 && !oe0) ?
                   (mem0[adrs0] | ((stuck && adrs0 == 4'h5) ? 4'h1 : 4'h0)) : 4'h0;
    assign dout1 = (!ce1 && !oe1) ? mem1[adrs1] : 4'h0;

    always @(posedge we0) if (ce0 == 1'b0) mem0[adrs0] <= bus0;
    always @(posedge we1) if (ce1 == 1'b0) mem1[adrs1] <= bus1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle; returns #1 after the accepting edge.
    task automatic applyStimulus(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Records {_ce,_we,_oe,wdrive,adrs,wdata} after each edge k+n.
    task automatic runUntilDone(input int which, input int abort_at, input int pulse_a,
                                input int pulse_b, output int n_out);
        int n;
        logic ce, we, oe, wd, dn;
        logic [3:0] a, d;
        n = 0;
        n_out = -1;
        while (n < 399) begin
            @(posedge clk);
            #1;
            n++;
            if (which == 0) begin
                ce = ce0; we = we0; oe = oe0; wd = wd0; a = adrs0; d = wdata0; dn = done0;
            end else begin
                ce = ce1; we = we1; oe = oe1; wd = wd1; a = adrs1; d = wdata1; dn = done1;
            end
            trace[n] = {ce, we, oe, wd, a, d};
            if (!we && !oe) overlap++;
            if (which == 0) start0 = (n == pulse_a) || (n == pulse_b);
            if ((n == abort_at) || dn) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        stuck  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_strobes", 32'({ce0, we0, oe0, wd0}), 32'b1110);
        checkOutput("reset_adrs_wdata", 32'({adrs0, wdata0}), 32'h0);
        checkOutput("reset_status", 32'({busy0, done0, pass0, err0}), 32'h0);
        checkOutput("reset_first_fail", 32'({ffa0, ffd0}), 32'h0);
        checkOutput("reset_strobes1", 32'({ce1, we1, oe1, wd1}), 32'b1110);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] fault-free run, default strobe width");
        applyStimulus(0);
        checkOutput("t1_busy_after_start", 32'({busy0, done0}), 32'b10);
        runUntilDone(0, -1, -1, -1, n_done);
        checkOutput("t1_done_edge", 32'(n_done), 32'd256);
        checkOutput("t2_w3_setup", 32'(trace[12]), 32'h733);
        checkOutput("t2_w3_strobe_a", 32'(trace[13]), 32'h333);
        checkOutput("t2_w3_strobe_b", 32'(trace[14]), 32'h333);
        checkOutput("t2_w3_hold", 32'(trace[15]), 32'h733);
        checkOutput("t2_w4_setup", 32'(trace[16]), 32'h744);
        checkOutput("t2_r0_strobe", 32'(trace[65][11:4]), 32'h40);
        checkOutput("t1_result", 32'({busy0, done0, pass0}), 32'b011);
        checkOutput("t1_err", 32'(err0), 32'd0);
        checkOutput("t1_first_fail", 32'({ffa0, ffd0}), 32'h0);
        checkOutput("t1_mem7", 32'(mem0[7]), 32'h8);
        checkOutput("t1_idle_strobes", 32'({ce0, we0, oe0, wd0}), 32'b1110);

        $display("[TB] stuck-at-1 on bit0 of cell 5");
        stuck = 1'b1;
        applyStimulus(0);
        checkOutput("t5_restart_done_drops", 32'({busy0, done0, pass0}), 32'b100);
        runUntilDone(0, -1, -1, -1, n_done);
        checkOutput("t3_done_edge", 32'(n_done), 32'd256);
        checkOutput("t3_pass", 32'({done0, pass0}), 32'b10);
        checkOutput("t3_err", 32'(err0), 32'd1);
        checkOutput("t3_ff_adrs", 32'(ffa0), 32'h5);
        checkOutput("t3_ff_data", 32'(ffd0), 32'hB);

        $display("[TB] reset during access 25");
        stuck = 1'b0;
        applyStimulus(0);
        checkOutput("t4_cleared_on_start",
                    32'({busy0, done0, pass0, err0, ffa0, ffd0}), 32'({3'b100, 14'd0}));
        runUntilDone(0, 101, -1, -1, n_done);
        checkOutput("t4_abort_point", 32'(n_done), 32'd101);
        checkOutput("t4_mid_strobe", 32'(trace[101][11:4]), 32'h49);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4_reset_strobes", 32'({ce0, we0, oe0, wd0}), 32'b1110);
        checkOutput("t4_reset_status", 32'({busy0, done0, adrs0}), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] rerun with start pulses while busy");
        applyStimulus(0);
        runUntilDone(0, -1, 50, 120, n_done);
        checkOutput("t5_done_edge", 32'(n_done), 32'd256);
        checkOutput("t4_rerun_result", 32'({pass0, err0}), 32'({1'b1, 6'd0}));
        applyStimulus(0);
        checkOutput("t5_done_drops_next", 32'({busy0, done0}), 32'b10);

        $display("[TB] single-cycle strobe instance");
        applyStimulus(1);
        runUntilDone(1, -1, -1, -1, n_done);
        checkOutput("t6_done_edge", 32'(n_done), 32'd192);
        checkOutput("t6_w3_setup", 32'(trace[9]), 32'h733);
        checkOutput("t6_w3_strobe", 32'(trace[10]), 32'h333);
        checkOutput("t6_w3_hold", 32'(trace[11]), 32'h733);
        checkOutput("t6_r0_strobe", 32'(trace[49][11:4]), 32'h40);
        checkOutput("t6_result", 32'({done1, pass1, err1, ffa1, ffd1}), 32'({2'b11, 14'd0}));
        checkOutput("no_we_oe_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
